lbp_hist: RTL and testbench

Downstream consumer of the LBP feature stage. It accumulates the 8-bit LBP codes produced for a 128×128 gray image into a 256-bin histogram. When the LBP stage raises `finish`, it streams the bins out over a valid/ready interface. Bin counts are held in a register array, so accumulation never back-pressures the LBP stage, which has no stall input.

---
 rtl/lbp_pkg.sv | 30 +++
 rtl/lbp_hist_if.sv | 30 +++
 rtl/lbp_hist_bank.sv | 49 ++++
 rtl/lbp_hist.sv | 112 +++++++++++
 tb/tb_lbp_hist.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lbp_pkg.sv
// lbp_pkg: types and constants shared by the LBP feature stage and its
// histogram consumer (lbp_hist).
package lbp_pkg;

  // Image geometry; the LBP stage and the histogram agree on the last address.
  localparam int IMG_W         = 128;
  localparam int LBP_LAST_ADDR = 16254;

  // Histogram defaults.
  localparam int CNT_W_DEFAULT = 14;   // holds 126*126 = 15876
  localparam int NBIN_DEFAULT  = 256;  // one bin per 8-bit LBP code
  localparam int BIN_W         = 8;
  localparam int ADDR_W        = 14;
  localparam int TOTAL_W       = 14;

  // Histogram controller states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC   = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // True when the bin index is the last one streamed out.
  function automatic logic is_last_bin(input logic [BIN_W-1:0] bin);
    return bin == BIN_W'(NBIN_DEFAULT - 1);
  endfunction

endpackage

// File: rtl/lbp_hist_if.sv
// lbp_hist_if: LBP code input stream and histogram drain stream of lbp_hist.
// slave  = the histogram block's view (codes in, bins out).
// master = the environment's view (drives codes and hist_ready).
interface lbp_hist_if #(
  parameter int CNT_W = lbp_pkg::CNT_W_DEFAULT
);
  // Code stream from the LBP stage (no back-pressure).
  logic                              lbp_valid;
  logic [lbp_pkg::ADDR_W-1:0]        lbp_addr;
  logic [lbp_pkg::BIN_W-1:0]         lbp_data;
  logic                              lbp_finish;

  // Bin drain stream (valid/ready) and status.
  logic                              hist_valid;
  logic                              hist_ready;
  logic [lbp_pkg::BIN_W-1:0]         hist_addr;
  logic [CNT_W-1:0]                  hist_data;
  logic [lbp_pkg::TOTAL_W-1:0]       hist_total;
  logic                              hist_done;

  modport slave (
    input  lbp_valid, lbp_addr, lbp_data, lbp_finish, hist_ready,
    output hist_valid, hist_addr, hist_data, hist_total, hist_done
  );

  modport master (
    output lbp_valid, lbp_addr, lbp_data, lbp_finish, hist_ready,
    input  hist_valid, hist_addr, hist_data, hist_total, hist_done
  );
endinterface

// File: rtl/lbp_hist_bank.sv
// lbp_hist_bank: NBIN x CNT_W register array of bin counters with one
// increment port and an asynchronous read port used by the drain.
// Optional macro LBP_HIST_SAT_EN: counters saturate at all-ones instead
// of wrapping.
module lbp_hist_bank
  import lbp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int NBIN  = NBIN_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en,
  input  logic [BIN_W-1:0] inc_bin,
  input  logic [BIN_W-1:0] rd_bin,
  output logic [CNT_W-1:0] rd_count
);

  logic [CNT_W-1:0] bin_reg [NBIN];
  logic [CNT_W-1:0] cur_count;
  logic [CNT_W-1:0] next_count;

  assign cur_count = bin_reg[inc_bin];

  // Next value of the addressed counter: +1, wrapping or saturating.
  always_comb begin
    next_count = cur_count + CNT_W'(1);
`ifdef LBP_HIST_SAT_EN
    if (cur_count == '1) begin
      next_count = cur_count;
    end
`endif
  end

  // Clear all bins on reset; otherwise bump the addressed bin.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBIN; i++) begin
        bin_reg[i] <= '0;
      end
    end else if (inc_en) begin
      bin_reg[inc_bin] <= next_count;
    end
  end

  // Registers make the read port combinational; a saturated bin reads all-ones.
  assign rd_count = bin_reg[rd_bin];

endmodule

// File: rtl/lbp_hist.sv
// lbp_hist: accumulates 8-bit LBP codes into a 256-bin histogram and, once
// the LBP stage raises lbp_finish, streams the bins out over valid/ready.
// Optional macro LBP_HIST_SAT_EN (see lbp_hist_bank): saturating bins.
module lbp_hist
  import lbp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int NBIN  = NBIN_DEFAULT
) (
  input  logic  clk,
  input  logic  reset,
  lbp_hist_if.slave bus
);

  state_t             state;
  logic               s_vld;
  logic [BIN_W-1:0]   s_bin;
  logic [TOTAL_W-1:0] total_reg;
  logic               hist_valid_reg;
  logic [BIN_W-1:0]   hist_addr_reg;
  logic               hist_done_reg;
  logic               accept;
  logic [CNT_W-1:0]   rd_count;
  logic               addr_unused;

  // Codes only count while waiting for or inside the accumulation phase;
  // anything later is an upstream protocol violation and is dropped.
  assign accept = bus.lbp_valid && ((state == IDLE) || (state == ACC));

  // The pixel address only feeds an optional simulation check upstream.
  assign addr_unused = ^bus.lbp_addr;

  // Stage 1 of the update pipeline plus the stage-2 code total.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_vld     <= 1'b0;
      s_bin     <= '0;
      total_reg <= '0;
    end else begin
      s_vld <= accept;
      s_bin <= bus.lbp_data;
      if (s_vld) begin
        total_reg <= total_reg + TOTAL_W'(1);
      end
    end
  end

  // Stage 2: the bin array increments s_bin; no forwarding is needed.
  lbp_hist_bank #(
    .CNT_W (CNT_W),
    .NBIN  (NBIN)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .inc_en   (s_vld),
    .inc_bin  (s_bin),
    .rd_bin   (hist_addr_reg),
    .rd_count (rd_count)
  );

  // Controller FSM with registered drain outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      hist_valid_reg <= 1'b0;
      hist_addr_reg  <= '0;
      hist_done_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.lbp_valid) begin
            state <= ACC;
          end
        end
        ACC: begin
          if (bus.lbp_finish) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          // The last code lands in the bank on this edge; bins are final.
          state          <= DRAIN;
          hist_valid_reg <= 1'b1;
        end
        DRAIN: begin
          if (hist_valid_reg && bus.hist_ready) begin
            if (is_last_bin(hist_addr_reg)) begin
              hist_valid_reg <= 1'b0;
              hist_done_reg  <= 1'b1;
              state          <= DONE;
            end else begin
              hist_addr_reg <= hist_addr_reg + BIN_W'(1);
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.hist_valid = hist_valid_reg;
  assign bus.hist_addr  = hist_addr_reg;
  assign bus.hist_data  = rd_count;
  assign bus.hist_total = total_reg;
  assign bus.hist_done  = hist_done_reg;

endmodule

// File: tb/tb_lbp_hist.sv
// tb_lbp_hist: self-checking bench for lbp_hist. A table of accumulation
// runs plus hand-written sequences for pipeline timing, post-DONE codes,
// reset mid-drain and counter overflow (second instance with CNT_W = 4).
module tb_lbp_hist;
  import lbp_pkg::*;

`ifdef LBP_HIST_SAT_EN
  localparam int SAT_EXP = 15;
`else
  localparam int SAT_EXP = 4;
`endif
  localparam int DRAIN_LIMIT = 4000;

  logic clk = 1'b0;
  logic reset;
  logic reset4;

  always #5 clk = ~clk;

  lbp_hist_if #(.CNT_W(14)) ifc ();
  lbp_hist_if #(.CNT_W(4))  ifc4 ();

  lbp_hist #(.CNT_W(14), .NBIN(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  lbp_hist #(.CNT_W(4), .NBIN(256)) dut4 (
    .clk   (clk),
    .reset (reset4),
    .bus   (ifc4)
  );

  typedef struct {
    int addr;
    int data;
  } exp_t;

  // mode: 0 constant code, 1 cyclic 0..255, 2 random
  // rmode: 0 ready high, 1 ready 1,0,0 repeating, 2 random ready
  typedef struct {
    int mode;
    int n;
    int code;
    int rmode;
    int bin_a;
    int exp_a;
    int bin_b;
    int exp_b;
    int exp_total;
  } run_t;

  int   checks = 0;
  int   errors = 0;
  int   model_bin [256];
  int   model_total;
  int   got_bin [256];
  exp_t exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model_bin[i] = 0;
    model_total = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, int'(ifc.hist_valid), 0);
    chk({tag, "_addr"},  int'(ifc.hist_addr),  0);
    chk({tag, "_data"},  int'(ifc.hist_data),  0);
    chk({tag, "_total"}, int'(ifc.hist_total), 0);
    chk({tag, "_done"},  int'(ifc.hist_done),  0);
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    reset           = 1'b1;
    ifc.lbp_valid   = 1'b0;
    ifc.lbp_finish  = 1'b0;
    ifc.hist_ready  = 1'b0;
    @(negedge clk);
    if (check) check_reset_vals("reset");
    reset = 1'b0;
    clear_model();
  endtask

  // Drive n codes back to back, then raise lbp_finish in the next cycle.
  task automatic feed(input int mode, input int n, input int code);
    int d;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (mode == 0)      d = code;
      else if (mode == 1) d = k % 256;
      else                d = int'($urandom_range(0, 255));
      ifc.lbp_valid = 1'b1;
      ifc.lbp_data  = 8'(d);
      ifc.lbp_addr  = 14'(k);
      model_bin[d]  = (model_bin[d] + 1) & 16383;
      model_total   = (model_total + 1) & 16383;
    end
    @(negedge clk);
    ifc.lbp_valid  = 1'b0;
    ifc.lbp_finish = 1'b1;
  endtask

  // Drain all bins through the scoreboard; stalled cycles must hold the head.
  task automatic drain(input int rmode, input string tag);
    int   cyc;
    int   nx;
    exp_t e;
    bit   rdy;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      e.addr = i;
      e.data = model_bin[i];
      exp_q.push_back(e);
      got_bin[i] = -1;
    end
    cyc = 0;
    nx  = 0;
    while (!ifc.hist_done && cyc < DRAIN_LIMIT) begin
      @(negedge clk);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = ($urandom_range(0, 1) != 0);
      endcase
      ifc.hist_ready = rdy;
      if (ifc.hist_valid) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_valid"}, 1, 0);
        end else begin
          e = exp_q[0];
          chk({tag, "_addr"}, int'(ifc.hist_addr), e.addr);
          chk({tag, "_data"}, int'(ifc.hist_data), e.data);
          if (rdy) begin
            got_bin[e.addr] = int'(ifc.hist_data);
            void'(exp_q.pop_front());
            nx++;
          end
        end
      end
      cyc++;
    end
    ifc.hist_ready = 1'b0;
    chk({tag, "_timeout"},     int'(cyc >= DRAIN_LIMIT), 0);
    chk({tag, "_xfers"},       nx, 256);
    chk({tag, "_done"},        int'(ifc.hist_done), 1);
    chk({tag, "_valid_after"}, int'(ifc.hist_valid), 0);
    $display("drain %s: transfers=%0d cycles=%0d total=%0d", tag, nx, cyc, int'(ifc.hist_total));
  endtask

  initial begin
    run_t tbl [4];
    int   cyc;
    int   got;

    tbl[0] = '{0, 15876, 8'h00, 0, 8'h00, 15876, 8'h01, 0, 15876};
    tbl[1] = '{1, 15876, 0,     0, 8'h03, 63,    8'h04, 62, 15876};
    tbl[2] = '{0, 40,    8'h5A, 1, 8'h5A, 40,    8'h00, 0, 40};
    tbl[3] = '{2, 500,   0,     2, -1,    0,     -1,    0, 500};

    reset            = 1'b1;
    reset4           = 1'b1;
    ifc.lbp_valid    = 1'b0;
    ifc.lbp_addr     = '0;
    ifc.lbp_data     = '0;
    ifc.lbp_finish   = 1'b0;
    ifc.hist_ready   = 1'b0;
    ifc4.lbp_valid   = 1'b0;
    ifc4.lbp_addr    = '0;
    ifc4.lbp_data    = '0;
    ifc4.lbp_finish  = 1'b0;
    ifc4.hist_ready  = 1'b0;
    clear_model();

    // Table-driven accumulation runs.
    for (int r = 0; r < 4; r++) begin
      do_reset(r == 0);
      feed(tbl[r].mode, tbl[r].n, tbl[r].code);
      drain(tbl[r].rmode, $sformatf("run%0d", r));
      chk($sformatf("run%0d_total", r), int'(ifc.hist_total), tbl[r].exp_total);
      chk($sformatf("run%0d_total_model", r), int'(ifc.hist_total), model_total);
      if (tbl[r].bin_a >= 0) chk($sformatf("run%0d_bin_a", r), got_bin[tbl[r].bin_a], tbl[r].exp_a);
      if (tbl[r].bin_b >= 0) chk($sformatf("run%0d_bin_b", r), got_bin[tbl[r].bin_b], tbl[r].exp_b);
    end

    // Three 0xA5 codes, lbp_finish with the third; check pipeline timing.
    do_reset(0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ifc.lbp_valid = 1'b1;
      ifc.lbp_data  = 8'hA5;
      ifc.lbp_addr  = 14'(LBP_LAST_ADDR - 2 + k);
      if (k == 2) ifc.lbp_finish = 1'b1;
      model_bin[8'hA5]++;
      model_total++;
    end
    @(negedge clk);
    ifc.lbp_valid = 1'b0;
    chk("a5_total_pre",  int'(ifc.hist_total), 2);
    chk("a5_valid_pre",  int'(ifc.hist_valid), 0);
    @(negedge clk);
    chk("a5_total",      int'(ifc.hist_total), 3);
    chk("a5_valid_rise", int'(ifc.hist_valid), 1);
    chk("a5_addr0",      int'(ifc.hist_addr),  0);
    drain(0, "a5");
    chk("a5_bin", got_bin[8'hA5], 3);
    // Codes after DONE must be ignored.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ifc.lbp_valid = 1'b1;
      ifc.lbp_data  = 8'h10;
    end
    @(negedge clk);
    ifc.lbp_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_done_total", int'(ifc.hist_total), 3);
    chk("post_done_done",  int'(ifc.hist_done),  1);
    $display("sequence a5: total=%0d", int'(ifc.hist_total));

    // Reset at bin 100 of a drain, then a fresh 10-code run.
    do_reset(0);
    feed(0, 300, 8'h77);
    ifc.hist_ready = 1'b1;
    cyc = 0;
    while (!(ifc.hist_valid && ifc.hist_addr == 8'd100) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reach_bin100", int'(ifc.hist_addr), 100);
    reset          = 1'b1;
    ifc.hist_ready = 1'b0;
    ifc.lbp_finish = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_reset");
    reset = 1'b0;
    clear_model();
    feed(0, 10, 8'h3C);
    drain(0, "after_reset");
    chk("after_reset_bin3c", got_bin[8'h3C], 10);
    chk("after_reset_bin77", got_bin[8'h77], 0);
    chk("after_reset_total", int'(ifc.hist_total), 10);
    $display("sequence mid-drain reset: bin3c=%0d", got_bin[8'h3C]);

    // Overflow on the CNT_W = 4 instance: 20 codes of 0x11.
    @(negedge clk);
    reset4 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ifc4.lbp_valid = 1'b1;
      ifc4.lbp_data  = 8'h11;
    end
    @(negedge clk);
    ifc4.lbp_valid  = 1'b0;
    ifc4.lbp_finish = 1'b1;
    ifc4.hist_ready = 1'b1;
    got = -1;
    cyc = 0;
    while (!ifc4.hist_done && cyc < 1000) begin
      @(negedge clk);
      if (ifc4.hist_valid && ifc4.hist_addr == 8'h11) got = int'(ifc4.hist_data);
      cyc++;
    end
    chk("ovf_timeout", int'(cyc >= 1000), 0);
    chk("ovf_bin11",   got, SAT_EXP);
    chk("ovf_total",   int'(ifc4.hist_total), 20);
    chk("ovf_done",    int'(ifc4.hist_done), 1);
    $display("sequence overflow: bin11=%0d", got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
